updown_counter_param: RTL and testbench
=======================================

# updown_counter_param

Parametrised synchronous up/down counter with programmable modulus, wrap or saturate mode, enable, parallel load, and boundary flags. Next generation of the team's fixed 4-bit up/down counter. Used as a general event/index counter wherever width, count range, or boundary reporting must be configurable. Single clock domain; all outputs registered.

## Interface

- WIDTH, 4: counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1: terminal count. The count range is 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.

- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- en_i  in  1  count enable; one step per cycle while high.
- sel_i  in  1  direction: 1 = up, 0 = down.
- load_i  in  1  parallel load strobe.
- load_data_i  in  WIDTH  load value.
- data_o  out  WIDTH  current count.
- tc_o  out  1  one-cycle pulse marking a boundary event.
- ovf_o  out  1  sticky flag for an up-boundary event.
- unf_o  out  1  sticky flag for a down-boundary event.

## Operation

- Priority per rising edge: reset, then load, then count, then hold.
- Reset (rst_n = 0 at the edge):
  - data_o = 0, tc_o = 0, ovf_o = 0, unf_o = 0.
  - All other inputs are ignored.
- Load (load_i = 1):
  - data_o = min(load_data_i, MAX_VAL); out-of-range values clamp to MAX_VAL.
  - ovf_o and unf_o clear.
  - tc_o = 0.
  - en_i is ignored.
- Count up (en_i = 1, sel_i = 1):
  - data_o < MAX_VAL: data_o + 1.
  - data_o == MAX_VAL: boundary event. Next value is 0 when SATURATE = 0, MAX_VAL when SATURATE = 1.
- Count down (en_i = 1, sel_i = 0):
  - data_o > 0: data_o - 1.
  - data_o == 0: boundary event. Next value is MAX_VAL when SATURATE = 0, 0 when SATURATE = 1.
- Boundary event, both modes:
  - tc_o = 1 for exactly the cycle after the edge at which the event occurred.
  - Up-boundary sets ovf_o; down-boundary sets unf_o.
  - Flags stay set until load or reset.
  - In saturate mode, every enabled cycle spent pushing against the boundary is a new event, so tc_o stays high continuously.
- Hold (en_i = 0, load_i = 0): data_o and the sticky flags are unchanged; tc_o = 0.
- Arithmetic:
  - Modulo MAX_VAL+1, not 2**WIDTH.
  - The internal next-value path is WIDTH bits; the boundary compare prevents any carry out of the word.
- Direction may change on any cycle with no penalty; each cycle's step uses that cycle's sel_i.
- Reset mid-count overrides load and enable in the same cycle. Counting resumes on the first enabled cycle after rst_n returns high.

## Timing

- Latency is 1 cycle: inputs sampled at edge N appear on data_o and the flags after edge N.
- tc_o, ovf_o and unf_o update on the same edge as data_o, so they are consistent with the new count.
- Throughput is one step per cycle.
- No combinational path from any input to any output.

## Test plan

Parameters for all scenarios: WIDTH = 4, MAX_VAL = 9, SATURATE = 0 unless stated.

- **Reset:** hold rst_n = 0 for 2 cycles with en_i = 1 and load_i = 1 -> data_o = 0, tc_o = 0, ovf_o = 0, unf_o = 0. Release with en_i = 1, sel_i = 1 -> data_o reads 1, 2, 3 on successive cycles.
- **Up wrap:** load 8, then up for 3 cycles -> data_o 9, 0, 1. tc_o is high only in the cycle data_o = 0. ovf_o goes to 1 and stays 1.
- **Down wrap:** load 1, then down for 3 cycles -> data_o 0, 9, 8. tc_o is high only when data_o = 9. unf_o = 1, ovf_o = 0.
- **Saturate (SATURATE = 1):**
  - Load 8, up for 4 cycles -> data_o 9, 9, 9, 9; tc_o high on cycles 2-4.
  - Down from 0 for 2 cycles -> data_o holds 0, tc_o high, unf_o = 1.
- **Load clamp and priority:**
  - load_data_i = 15 with en_i = 1 -> data_o = 9, flags cleared.
  - Load and reset in the same cycle -> data_o = 0.
- **Enable gating and direction change:**
  - From 5: up, up, en_i = 0 for 2 cycles, then down -> data_o 6, 7, 7, 7, 6.
  - tc_o stays 0 throughout.

Source files
------------

// File: rtl/updown_counter_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : updown_counter_param                                     |
// | Description : Parametrised synchronous up/down counter with a          |
// |               programmable terminal count, wrap or saturate mode,      |
// |               enable, clamped parallel load, a boundary pulse and      |
// |               sticky overflow/underflow flags. All outputs registered. |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module updown_counter_param #(
   parameter int unsigned           WIDTH    = 4,
   parameter logic [WIDTH-1:0]      MAX_VAL  = {WIDTH{1'b1}},
   parameter bit                    SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             sel_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             tc_o,
   output logic             ovf_o,
   output logic             unf_o
);

   localparam logic [WIDTH-1:0] c_max  = MAX_VAL;
   localparam logic [WIDTH-1:0] c_zero = '0;
   localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_ovf;
   logic             r_unf;

   logic [WIDTH-1:0] w_next;
   logic             w_tc;
   logic             w_ovf;
   logic             w_unf;
   logic [WIDTH-1:0] w_load_val;
   logic             w_at_max;
   logic             w_at_zero;

   // Out-of-range load values clamp to the terminal count.
   assign w_load_val = (load_data_i > c_max) ? c_max : load_data_i;
   assign w_at_max   = (r_count == c_max);
   assign w_at_zero  = (r_count == c_zero);

   // Next-state selection: load beats count, count beats hold. The boundary
   // compares keep the +1/-1 path inside the WIDTH-bit word.
   always_comb begin
      w_next = r_count;
      w_tc   = 1'b0;
      w_ovf  = r_ovf;
      w_unf  = r_unf;
      if (load_i) begin
         w_next = w_load_val;
         w_ovf  = 1'b0;
         w_unf  = 1'b0;
      end else if (en_i) begin
         if (sel_i) begin
            if (w_at_max) begin
               w_tc   = 1'b1;
               w_ovf  = 1'b1;
               w_next = SATURATE ? c_max : c_zero;
            end else begin
               w_next = r_count + c_one;
            end
         end else begin
            if (w_at_zero) begin
               w_tc   = 1'b1;
               w_unf  = 1'b1;
               w_next = SATURATE ? c_zero : c_max;
            end else begin
               w_next = r_count - c_one;
            end
         end
      end
   end

   // State register with synchronous active-low reset overriding everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= c_zero;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_count <= w_next;
         r_tc    <= w_tc;
         r_ovf   <= w_ovf;
         r_unf   <= w_unf;
      end
   end

   assign data_o = r_count;
   assign tc_o   = r_tc;
   assign ovf_o  = r_ovf;
   assign unf_o  = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_updown_counter_param                                  |
// | Description : Self-checking bench for updown_counter_param. A wrap and |
// |               a saturate instance (WIDTH=4, MAX_VAL=9) share stimulus  |
// |               and are compared every cycle against a reference model.  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_updown_counter_param;

   localparam int c_max = 9;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en_i = 1'b0;
   logic       sel_i = 1'b0;
   logic       load_i = 1'b0;
   logic [3:0] load_data_i = 4'd0;

   logic [3:0] data_w, data_s;
   logic       tc_w, tc_s, ovf_w, ovf_s, unf_w, unf_s;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   // Reference model state: index 0 = wrap instance, 1 = saturate instance.
   int m_cnt [2];
   int m_tc  [2];
   int m_ovf [2];
   int m_unf [2];

   // 100 MHz clock.
   always #5 clk = ~clk;

   updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_dut_wrap (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .sel_i(sel_i), .load_i(load_i),
      .load_data_i(load_data_i), .data_o(data_w), .tc_o(tc_w), .ovf_o(ovf_w), .unf_o(unf_w)
   );

   updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .sel_i(sel_i), .load_i(load_i),
      .load_data_i(load_data_i), .data_o(data_s), .tc_o(tc_s), .ovf_o(ovf_s), .unf_o(unf_s)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   // Apply one edge's worth of inputs to the model, using modular/min/max arithmetic.
   task automatic model_edge(input int k, input logic rn, input logic ld, input int d,
                             input logic en, input logic sel);
      bit sat;
      sat = (k == 1);
      if (!rn) begin
         m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end else if (ld) begin
         m_cnt[k] = (d > c_max) ? c_max : d;
         m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end else if (en && sel) begin
         m_tc[k] = (m_cnt[k] == c_max) ? 1 : 0;
         if (m_tc[k] == 1) m_ovf[k] = 1;
         if (sat) m_cnt[k] = (m_cnt[k] + 1 > c_max) ? c_max : m_cnt[k] + 1;
         else     m_cnt[k] = (m_cnt[k] + 1) % (c_max + 1);
      end else if (en) begin
         m_tc[k] = (m_cnt[k] == 0) ? 1 : 0;
         if (m_tc[k] == 1) m_unf[k] = 1;
         if (sat) m_cnt[k] = (m_cnt[k] - 1 < 0) ? 0 : m_cnt[k] - 1;
         else     m_cnt[k] = (m_cnt[k] + c_max) % (c_max + 1);
      end else begin
         m_tc[k] = 0;
      end
   endtask

   // Drive one cycle, advance the model, and compare both instances after the edge.
   task automatic step(input logic rn, input logic ld, input int d, input logic en, input logic sel);
      rst_n = rn; load_i = ld; load_data_i = d[3:0]; en_i = en; sel_i = sel;
      @(posedge clk);
      cyc++;
      model_edge(0, rn, ld, d, en, sel);
      model_edge(1, rn, ld, d, en, sel);
      #1;
      check("wrap_data", int'(data_w), m_cnt[0]);
      check("wrap_tc",   int'(tc_w),   m_tc[0]);
      check("wrap_ovf",  int'(ovf_w),  m_ovf[0]);
      check("wrap_unf",  int'(unf_w),  m_unf[0]);
      check("sat_data",  int'(data_s), m_cnt[1]);
      check("sat_tc",    int'(tc_s),   m_tc[1]);
      check("sat_ovf",   int'(ovf_s),  m_ovf[1]);
      check("sat_unf",   int'(unf_s),  m_unf[1]);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end
      #2;

      // Reset held with load and enable active; then count up 1, 2, 3.
      step(1'b0, 1'b1, 7, 1'b1, 1'b1);
      step(1'b0, 1'b1, 7, 1'b1, 1'b1);
      check("rst_data_lit", int'(data_w), 0);
      step(1'b1, 1'b0, 0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 0, 1'b1, 1'b1);
      check("rst_release_lit", int'(data_w), 3);

      // Up wrap: load 8, up x3 -> 9, 0, 1 (saturate: 9, 9, 9).
      step(1'b1, 1'b1, 8, 1'b0, 1'b1);
      step(1'b1, 1'b0, 0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 0, 1'b1, 1'b1);
      check("upwrap_tc_lit", int'(tc_w), 1);
      step(1'b1, 1'b0, 0, 1'b1, 1'b1);
      check("upwrap_data_lit", int'(data_w), 1);
      check("upwrap_ovf_lit", int'(ovf_w), 1);
      check("sat_hold_lit", int'(data_s), 9);
      check("sat_tc_lit", int'(tc_s), 1);

      // Down wrap: load 1, down x3 -> 0, 9, 8.
      step(1'b1, 1'b1, 1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 0, 1'b1, 1'b0);
      check("dnwrap_data_lit", int'(data_w), 9);
      step(1'b1, 1'b0, 0, 1'b1, 1'b0);
      check("dnwrap_unf_lit", int'(unf_w), 1);
      check("dnwrap_ovf_lit", int'(ovf_w), 0);

      // Saturate: four pushes up from 8, then two pushes down from 0.
      step(1'b1, 1'b1, 8, 1'b0, 1'b1);
      repeat (4) step(1'b1, 1'b0, 0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 0, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 0, 1'b1, 1'b0);
      check("sat_floor_lit", int'(data_s), 0);

      // Load clamp with enable high, then load together with reset.
      step(1'b1, 1'b1, 15, 1'b1, 1'b1);
      check("clamp_lit", int'(data_w), 9);
      step(1'b0, 1'b1, 5, 1'b1, 1'b1);
      check("ld_rst_lit", int'(data_w), 0);

      // Enable gating and direction change from 5: 6, 7, 7, 7, 6.
      step(1'b1, 1'b1, 5, 1'b0, 1'b1);
      step(1'b1, 1'b0, 0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 0, 1'b1, 1'b0);
      check("gate_data_lit", int'(data_w), 6);
      check("gate_tc_lit", int'(tc_w), 0);

      // Randomised traffic; loads over the full 4-bit range exercise clamping.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) >= 3) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
              int'($urandom_range(0, 15)),
              ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
